bus_arbitrator_rr: RTL and testbench
====================================

Name: bus_arbitrator_rr

Overview:
N-master shared-bus arbitrator. It generalises the fixed two-master CPU/DMA arbitrator to NUM_MASTERS requesters and adds the following:
- Selectable fixed-priority or round-robin arbitration.
- Bus lock for atomic sequences.
- Optional turnaround gap between owners.
- Hold-time fairness: the owner is asked to yield, and is revoked at a transfer boundary marked by fc_bus.

It sits between the masters (CPU, DMA channels, debug) and the shared addr/data/rd/wr/mask bus. It drives grants only; bus muxing is done outside this block, keyed on grant.

Parameters:
NUM_MASTERS, 4, number of requesters (2..16)
ROUND_ROBIN, 1, 1 = round-robin; 0 = fixed priority with index 0 highest
MAX_HOLD, 16, contended-ownership cycles before yield is raised; 0 disables yield and revocation
TURNAROUND, 1, 1 = one all-idle cycle between different owners; 0 = direct handover

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
req  in  NUM_MASTERS  per-master bus request, held for the whole ownership
lock  in  NUM_MASTERS  per-master lock; honoured only for the current owner
fc_bus  in  1  single-cycle pulse marking a completed bus transfer
grant  out  NUM_MASTERS  one-hot or zero; registered
busy  out  1  OR of grant; registered
owner  out  $clog2(NUM_MASTERS)  index of current/last owner; registered
yield  out  NUM_MASTERS  request to the owner to release; registered, at most one bit set

Behaviour:
- Reset (async): grant=0, busy=0, owner=0, yield=0, hold counter=0, state=IDLE, RR last pointer=NUM_MASTERS-1 (so master 0 wins first).
- States:
  - IDLE: no grant.
  - OWNED: exactly one grant.
  - TURN: one dead cycle; exists only when TURNAROUND=1.
- Winner selection is combinational from req at the sampling edge:
  - Fixed priority: lowest set index wins.
  - Round-robin: first set index after the last pointer, scanning cyclically.
  - The last pointer updates to the winner on every grant.
- IDLE -> OWNED: any req set at edge k gives grant[winner]=1 after edge k, i.e. one cycle of latency. A request that drops before the sampling edge is not granted.
- OWNED, release: owner req sampled low at an edge clears grant at that edge. Next state:
  - TURNAROUND=1 and another req pending -> TURN. After TURN, the winner is re-chosen from req sampled at the end of TURN -> OWNED, or IDLE if none.
  - TURNAROUND=0 and another req pending -> grant moves to the new winner on the same edge; no zero cycle.
  - Otherwise -> IDLE.
- Hold counter:
  - Increments each OWNED cycle while another master requests and lock[owner]=0.
  - Saturates at MAX_HOLD.
  - Clears on every ownership change and whenever lock[owner]=1.
- Yield and revocation:
  - yield[owner] is set at the edge where the counter equals MAX_HOLD, provided MAX_HOLD!=0, another req is pending and lock[owner]=0.
  - yield stays set until ownership ends.
  - While yield is set, fc_bus=1 at an edge revokes the grant at that edge (same next state as a release).
  - Without fc_bus the grant is never revoked.
- Lock:
  - lock[owner]=1 suppresses yield and revocation.
  - If yield is already set when lock rises, yield clears at the next edge.
  - Lock bits of non-owners are ignored; lock never creates a request.
- Simultaneous events:
  - Owner releases in the same cycle yield would rise: treated as a normal release; yield stays 0.
  - Owner reasserts req in its release cycle: treated as a new request. In RR mode it ranks last behind other requesters.
  - fc_bus while yield=0 has no effect.
- owner holds its value while IDLE or TURN. busy is 0 in TURN.
- Reset mid-ownership: grant drops immediately (asynchronously). After reset release, arbitration restarts from the IDLE/pointer reset state.

Test Plan:
1. Basic grant and release (10 ns clock, NUM_MASTERS=4, RR): rst pulse; req=0001 -> grant=0001 one edge later and busy=1. Drop req -> grant=0000 one edge later, busy=0, owner=0.
2. Round-robin rotation (MAX_HOLD=0): req=1111 held. Each owner drops then reasserts its own req after its ownership -> grant sequence 0001, 0000 (TURN), 0010, 0000, 0100, 0000, 1000, 0000, 0001.
3. Fixed priority and direct handover (ROUND_ROBIN=0, TURNAROUND=0): req=0110; master 1 releases -> grant goes 0010 -> 0100 on one edge, with no zero cycle.
4. Yield and revoke (MAX_HOLD=4): master 0 owns and master 2 requests -> yield=0001 after 4 contended cycles. fc_bus pulse -> grant=0000 at that edge, then grant=0100 after TURN.
5. Lock (MAX_HOLD=4): master 0 owns with lock[0]=1, master 1 requests for 20 cycles -> yield stays 0000 and fc_bus pulses are ignored. Drop lock -> yield=0001 4 cycles later.
6. Async reset: rst asserted mid-cycle while grant=0100 -> grant=0000, busy=0, yield=0000 before the next clock edge. After release with req=1000 -> grant=1000 one edge later.

Source files
------------

// File: rtl/bus_arbitrator_rr.sv
// N-master shared-bus grant arbiter with fixed-priority or round-robin selection,
// owner lock, optional turnaround cycle and hold-time yield/revocation.
`timescale 1ns/1ps

module bus_arbitrator_rr #(
    parameter int NUM_MASTERS = 4,
    parameter int ROUND_ROBIN = 1,
    parameter int MAX_HOLD    = 16,
    parameter int TURNAROUND  = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_MASTERS-1:0]         req,
    input  logic [NUM_MASTERS-1:0]         lock,
    input  logic                           fc_bus,
    output logic [NUM_MASTERS-1:0]         grant,
    output logic                           busy,
    output logic [$clog2(NUM_MASTERS)-1:0] owner,
    output logic [NUM_MASTERS-1:0]         yield
);

    // state   | meaning
    // S_IDLE  | no grant, waiting for any request
    // S_OWNED | exactly one master granted
    // S_TURN  | one dead cycle between different owners

    localparam int IW = $clog2(NUM_MASTERS);
    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

    typedef enum logic [1:0] {S_IDLE, S_OWNED, S_TURN} state_t;

    state_t                  state;
    logic [IW-1:0]           last_ptr;
    logic [CW-1:0]           hold_cnt;

    logic [NUM_MASTERS-1:0]  others;
    logic [IW-1:0]           win_all;
    logic [IW-1:0]           win_oth;
    logic [CW-1:0]           hold_inc;
    logic                    owner_lock;
    logic                    revoke;
    logic                    release_now;

    function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IW-1:0] idx);
        logic [NUM_MASTERS-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin scans cyclically starting just after the last winner.
    function automatic logic [IW-1:0] pick(input logic [NUM_MASTERS-1:0] r,
                                           input logic [IW-1:0] last);
        logic [IW-1:0] w;
        logic          found;
        int            idx;
        w     = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (ROUND_ROBIN != 0)
                idx = (int'(last) + 1 + i) % NUM_MASTERS;
            else
                idx = i;
            if (!found && r[idx]) begin
                w     = IW'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    always_comb begin
        others      = req & ~onehot(owner);
        win_all     = pick(req, last_ptr);
        win_oth     = pick(others, last_ptr);
        hold_inc    = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
        owner_lock  = lock[owner];
        revoke      = yield[owner] && fc_bus && !owner_lock;
        release_now = !req[owner] || revoke;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            grant    <= '0;
            busy     <= 1'b0;
            owner    <= '0;
            yield    <= '0;
            hold_cnt <= '0;
            last_ptr <= IW'(NUM_MASTERS - 1);
        end else begin
            case (state)
                S_IDLE, S_TURN: begin
                    if (|req) begin
                        state    <= S_OWNED;
                        grant    <= onehot(win_all);
                        busy     <= 1'b1;
                        owner    <= win_all;
                        last_ptr <= win_all;
                        hold_cnt <= '0;
                        yield    <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_OWNED: begin
                    if (release_now) begin
                        yield    <= '0;
                        hold_cnt <= '0;
                        if (|others) begin
                            if (TURNAROUND != 0) begin
                                state <= S_TURN;
                                grant <= '0;
                                busy  <= 1'b0;
                            end else begin
                                grant    <= onehot(win_oth);
                                owner    <= win_oth;
                                last_ptr <= win_oth;
                            end
                        end else begin
                            state <= S_IDLE;
                            grant <= '0;
                            busy  <= 1'b0;
                        end
                    end else if (owner_lock) begin
                        hold_cnt <= '0;
                        yield    <= '0;
                    end else if (|others) begin
                        hold_cnt <= hold_inc;
                        // yield rises on the edge where the count reaches MAX_HOLD
                        if (MAX_HOLD != 0 && hold_inc == HOLD_MAX)
                            yield <= onehot(owner);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbitrator_rr.sv
// Scoreboard bench for bus_arbitrator_rr: one round-robin/turnaround instance and
// one fixed-priority/direct-handover instance, directed vectors with hand-computed grants.
`timescale 1ns/1ps

module tb_bus_arbitrator_rr;

    typedef struct {
        string      name;
        bit         fp;
        logic [3:0] grant;
        logic       busy;
        logic [1:0] owner;
        logic [3:0] yield;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] req_rr, lock_rr, grant_rr, yield_rr;
    logic       fc_rr, busy_rr;
    logic [1:0] owner_rr;
    logic [3:0] req_fp, lock_fp, grant_fp, yield_fp;
    logic       fc_fp, busy_fp;
    logic [1:0] owner_fp;

    exp_t exp_q[$];
    event chk_ev;
    int   n_vec;
    int   n_bad;

    bus_arbitrator_rr #(.NUM_MASTERS(4), .ROUND_ROBIN(1), .MAX_HOLD(4), .TURNAROUND(1)) dut_rr (
        .clk(clk), .rst(rst), .req(req_rr), .lock(lock_rr), .fc_bus(fc_rr),
        .grant(grant_rr), .busy(busy_rr), .owner(owner_rr), .yield(yield_rr)
    );

    bus_arbitrator_rr #(.NUM_MASTERS(4), .ROUND_ROBIN(0), .MAX_HOLD(0), .TURNAROUND(0)) dut_fp (
        .clk(clk), .rst(rst), .req(req_fp), .lock(lock_fp), .fc_bus(fc_fp),
        .grant(grant_fp), .busy(busy_fp), .owner(owner_fp), .yield(yield_fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d entries pending", exp_q.size());
        $fatal(1);
    end

    // Monitor: drains the scoreboard on every falling edge or on an explicit mid-cycle check.
    initial begin
        exp_t e;
        logic [10:0] act;
        logic [10:0] want;
        forever begin
            @(negedge clk or chk_ev);
            while (exp_q.size() > 0) begin
                e    = exp_q.pop_front();
                act  = e.fp ? {grant_fp, busy_fp, owner_fp, yield_fp}
                            : {grant_rr, busy_rr, owner_rr, yield_rr};
                want = {e.grant, e.busy, e.owner, e.yield};
                n_vec++;
                if (act !== want) begin
                    n_bad++;
                    $display("FAIL %s: got grant=%b busy=%b owner=%0d yield=%b, want grant=%b busy=%b owner=%0d yield=%b",
                             e.name, act[10:7], act[6], act[5:4], act[3:0],
                             e.grant, e.busy, e.owner, e.yield);
                end
            end
        end
    end

    function automatic exp_t mk(input bit fp, input logic [3:0] g, input logic [1:0] o,
                                input logic [3:0] y, input string nm);
        exp_t e;
        e.name  = nm;
        e.fp    = fp;
        e.grant = g;
        e.busy  = |g;
        e.owner = o;
        e.yield = y;
        return e;
    endfunction

    // Drive one cycle of inputs; expectation applies after the next rising edge.
    task automatic cyc(input bit fp, input logic [3:0] r, input logic [3:0] l, input logic f,
                       input logic [3:0] g, input logic [1:0] o, input logic [3:0] y,
                       input string nm);
        if (fp) begin
            req_fp = r; lock_fp = l; fc_fp = f;
        end else begin
            req_rr = r; lock_rr = l; fc_rr = f;
        end
        exp_q.push_back(mk(fp, g, o, y, nm));
        @(negedge clk);
        #1;
    endtask

    task automatic check_now(input bit fp, input logic [3:0] g, input logic [1:0] o,
                             input logic [3:0] y, input string nm);
        exp_q.push_back(mk(fp, g, o, y, nm));
        ->chk_ev;
        #1;
    endtask

    task automatic do_reset();
        req_rr = '0; lock_rr = '0; fc_rr = 1'b0;
        req_fp = '0; lock_fp = '0; fc_fp = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        req_rr = '0; lock_rr = '0; fc_rr = 1'b0;
        req_fp = '0; lock_fp = '0; fc_fp = 1'b0;
        #12;
        check_now(0, 4'b0000, 2'd0, 4'b0000, "reset_rr");
        check_now(1, 4'b0000, 2'd0, 4'b0000, "reset_fp");
        rst = 1'b0;
        @(negedge clk);
        #1;

        // basic grant / release
        cyc(0, 4'b0001, 4'b0000, 1'b0, 4'b0001, 2'd0, 4'b0000, "basic_grant");
        cyc(0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, "basic_release");
        cyc(0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, "basic_idle");

        // round-robin rotation with turnaround
        do_reset();
        cyc(0, 4'b1111, 4'b0000, 1'b0, 4'b0001, 2'd0, 4'b0000, "rr_own0");
        cyc(0, 4'b1110, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, "rr_turn0");
        cyc(0, 4'b1111, 4'b0000, 1'b0, 4'b0010, 2'd1, 4'b0000, "rr_own1");
        cyc(0, 4'b1101, 4'b0000, 1'b0, 4'b0000, 2'd1, 4'b0000, "rr_turn1");
        cyc(0, 4'b1111, 4'b0000, 1'b0, 4'b0100, 2'd2, 4'b0000, "rr_own2");
        cyc(0, 4'b1011, 4'b0000, 1'b0, 4'b0000, 2'd2, 4'b0000, "rr_turn2");
        cyc(0, 4'b1111, 4'b0000, 1'b0, 4'b1000, 2'd3, 4'b0000, "rr_own3");
        cyc(0, 4'b0111, 4'b0000, 1'b0, 4'b0000, 2'd3, 4'b0000, "rr_turn3");
        cyc(0, 4'b1111, 4'b0000, 1'b0, 4'b0001, 2'd0, 4'b0000, "rr_wrap0");
        cyc(0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, "rr_idle");

        // fixed priority, direct handover, fc_bus ignored without yield
        do_reset();
        cyc(1, 4'b0110, 4'b0000, 1'b0, 4'b0010, 2'd1, 4'b0000, "fp_own1");
        cyc(1, 4'b0110, 4'b0000, 1'b1, 4'b0010, 2'd1, 4'b0000, "fp_fc_ignored");
        cyc(1, 4'b0100, 4'b0000, 1'b0, 4'b0100, 2'd2, 4'b0000, "fp_handover");
        cyc(1, 4'b0100, 4'b0000, 1'b0, 4'b0100, 2'd2, 4'b0000, "fp_hold2");
        cyc(1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd2, 4'b0000, "fp_idle");
        cyc(1, 4'b1010, 4'b0000, 1'b0, 4'b0010, 2'd1, 4'b0000, "fp_lowest_wins");
        cyc(1, 4'b1000, 4'b0000, 1'b0, 4'b1000, 2'd3, 4'b0000, "fp_handover3");
        cyc(1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd3, 4'b0000, "fp_idle3");

        // yield after 4 contended cycles, then revoke on fc_bus
        do_reset();
        cyc(0, 4'b0101, 4'b0000, 1'b0, 4'b0001, 2'd0, 4'b0000, "y_own0");
        cyc(0, 4'b0101, 4'b0000, 1'b0, 4'b0001, 2'd0, 4'b0000, "y_cnt1");
        cyc(0, 4'b0101, 4'b0000, 1'b1, 4'b0001, 2'd0, 4'b0000, "y_cnt2_fc_noyield");
        cyc(0, 4'b0101, 4'b0000, 1'b0, 4'b0001, 2'd0, 4'b0000, "y_cnt3");
        cyc(0, 4'b0101, 4'b0000, 1'b0, 4'b0001, 2'd0, 4'b0001, "y_raise");
        cyc(0, 4'b0101, 4'b0000, 1'b0, 4'b0001, 2'd0, 4'b0001, "y_hold_nofc");
        cyc(0, 4'b0101, 4'b0000, 1'b1, 4'b0000, 2'd0, 4'b0000, "y_revoke");
        cyc(0, 4'b0101, 4'b0000, 1'b0, 4'b0100, 2'd2, 4'b0000, "y_next_owner2");
        cyc(0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd2, 4'b0000, "y_idle");

        // lock suppresses yield and revocation
        do_reset();
        cyc(0, 4'b0011, 4'b0001, 1'b0, 4'b0001, 2'd0, 4'b0000, "lk_own0");
        for (int i = 0; i < 20; i++)
            cyc(0, 4'b0011, 4'b0001, (i % 3 == 2), 4'b0001, 2'd0, 4'b0000, "lk_locked");
        cyc(0, 4'b0011, 4'b0000, 1'b0, 4'b0001, 2'd0, 4'b0000, "lk_drop_c1");
        cyc(0, 4'b0011, 4'b0000, 1'b0, 4'b0001, 2'd0, 4'b0000, "lk_drop_c2");
        cyc(0, 4'b0011, 4'b0000, 1'b0, 4'b0001, 2'd0, 4'b0000, "lk_drop_c3");
        cyc(0, 4'b0011, 4'b0000, 1'b0, 4'b0001, 2'd0, 4'b0001, "lk_yield");
        cyc(0, 4'b0011, 4'b0001, 1'b1, 4'b0001, 2'd0, 4'b0000, "lk_relock_clears");
        cyc(0, 4'b0011, 4'b0000, 1'b0, 4'b0001, 2'd0, 4'b0000, "lk_restart");
        cyc(0, 4'b0010, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0000, "lk_release");
        cyc(0, 4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 4'b0000, "lk_owner1");
        cyc(0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd1, 4'b0000, "lk_idle");

        // asynchronous reset while master 2 owns
        do_reset();
        cyc(0, 4'b0100, 4'b0000, 1'b0, 4'b0100, 2'd2, 4'b0000, "ar_own2");
        #1;
        rst    = 1'b1;
        req_rr = 4'b1000;
        #1;
        check_now(0, 4'b0000, 2'd0, 4'b0000, "ar_async_drop");
        rst = 1'b0;
        cyc(0, 4'b1000, 4'b0000, 1'b0, 4'b1000, 2'd3, 4'b0000, "ar_regrant3");
        cyc(0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd3, 4'b0000, "ar_idle");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
